count_mode_decoder: RTL and testbench

//  Receive-side decoder for the 3-bit up/down/even/odd/hold counter.

---
 rtl/count_mode_decoder.sv | 135 +++++++++++++
 tb/tb_count_mode_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/count_mode_decoder.sv
// Receive-side decoder for the up/down/even/odd/hold counter: recovers the control word behind each state step.
// Optional saturating error counter is built when COUNT_ERR_STATS_EN is defined.
module count_mode_decoder #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       cnt_in,
    input  logic             cnt_vld,
    output logic [3:0]       x_out,
    output logic             x_vld,
    output logic             illegal,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned X_W   = 4;
    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [X_W-1:0]   x_d;
    logic             x_vld_d, illegal_d, locked_d;

    logic [CNT_W-1:0] delta;
    logic             p_even;
    logic             step_bad;
    logic             step_up;
    logic             step_two;

    // Step classification relative to the previous accepted sample (3-bit wrap).
    assign delta    = cnt_in - prev_q;
    assign p_even   = ~prev_q[0];
    assign step_bad = (delta == 3'd3) || (delta == 3'd4) || (delta == 3'd5);
    assign step_up  = (delta == 3'd1) || (delta == 3'd2);
    assign step_two = (delta == 3'd2) || (delta == 3'd6);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            prev_q  <= '0;
            run_q   <= '0;
            x_out   <= '0;
            x_vld   <= 1'b0;
            illegal <= 1'b0;
            locked  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            run_q   <= run_d;
            x_out   <= x_d;
            x_vld   <= x_vld_d;
            illegal <= illegal_d;
            locked  <= locked_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        run_d     = run_q;
        x_d       = x_out;
        x_vld_d   = 1'b0;
        illegal_d = 1'b0;
        locked_d  = locked;

        if (cnt_vld) begin
            prev_d = cnt_in;
            case (state_q)
                EMPTY: begin
                    state_d = TRACK;
                end
                TRACK, LOCKED: begin
                    if (step_bad) begin
                        illegal_d = 1'b1;
                        run_d     = '0;
                        locked_d  = 1'b0;
                        state_d   = TRACK;
                    end else begin
                        x_vld_d = 1'b1;
                        if (delta == 3'd0) begin
                            x_d[3] = 1'b1;
                        end else begin
                            // The step-size bit lands on even or odd by the parity of the source state.
                            x_d[3] = 1'b0;
                            x_d[0] = step_up;
                            if (p_even) begin
                                x_d[1] = step_two;
                            end else begin
                                x_d[2] = step_two;
                            end
                        end
                        if (run_q != RUN_W'(LOCK_CNT)) begin
                            run_d = run_q + RUN_W'(1);
                        end
                        if (run_d == RUN_W'(LOCK_CNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

`ifdef COUNT_ERR_STATS_EN
    logic [ERR_W-1:0] err_q;

    // Counts alongside the illegal pulse; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (illegal_d && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_count_mode_decoder.sv
// Table-driven scoreboard bench for count_mode_decoder (default LOCK_CNT=4).
module tb_count_mode_decoder;

    localparam int unsigned ERR_W = 8;

    logic             clk;
    logic             reset;
    logic [2:0]       cnt_in;
    logic             cnt_vld;
    logic [3:0]       x_out;
    logic             x_vld;
    logic             illegal;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    count_mode_decoder #(.LOCK_CNT(4), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .cnt_in  (cnt_in),
        .cnt_vld (cnt_vld),
        .x_out   (x_out),
        .x_vld   (x_vld),
        .illegal (illegal),
        .locked  (locked),
        .err_cnt (err_cnt)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [2:0] cnt;
        logic [3:0] x;
        logic       xv;
        logic       il;
        logic       lk;
    } vec_t;

    typedef struct {
        logic [3:0]       x;
        logic             xv;
        logic             il;
        logic             lk;
        logic [ERR_W-1:0] err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic [ERR_W-1:0] exp_err = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic vld, input logic [2:0] cnt,
                       input logic [3:0] x, input logic xv, input logic il, input logic lk);
        vec_t v;
        v.rst = rst; v.vld = vld; v.cnt = cnt; v.x = x; v.xv = xv; v.il = il; v.lk = lk;
        vecs.push_back(v);
    endtask

    // Drive one cycle, push its expectation, then pop and compare after the clock edge.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset   = v.rst;
        cnt_vld = v.vld;
        cnt_in  = v.cnt;
        if (v.rst) exp_err = '0;
        else if (v.il && exp_err != {ERR_W{1'b1}}) exp_err = exp_err + ERR_W'(1);
        e.x = v.x; e.xv = v.xv; e.il = v.il; e.lk = v.lk;
`ifdef COUNT_ERR_STATS_EN
        e.err = exp_err;
`else
        e.err = '0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check("x_out",   32'(x_out),   32'(got.x));
            check("x_vld",   32'(x_vld),   32'(got.xv));
            check("illegal", 32'(illegal), 32'(got.il));
            check("locked",  32'(locked),  32'(got.lk));
            check("err_cnt", 32'(err_cnt), 32'(got.err));
        end
    endtask

    initial begin
        vec_t v;
        reset   = 1'b1;
        cnt_vld = 1'b0;
        cnt_in  = 3'd0;

        // Counting up by one, lock after four legal steps, then idle and a delta-4 jump.
        add(1, 0, 3'd0, 4'b0000, 0, 0, 0);
        add(0, 1, 3'd0, 4'b0000, 0, 0, 0);
        add(0, 1, 3'd1, 4'b0001, 1, 0, 0);
        add(0, 1, 3'd2, 4'b0001, 1, 0, 0);
        add(0, 1, 3'd3, 4'b0001, 1, 0, 0);
        add(0, 1, 3'd4, 4'b0001, 1, 0, 1);
        add(0, 1, 3'd5, 4'b0001, 1, 0, 1);
        add(0, 0, 3'd7, 4'b0001, 0, 0, 1);
        add(0, 1, 3'd4, 4'b0000, 1, 0, 1);
        add(0, 1, 3'd2, 4'b0010, 1, 0, 1);
        add(0, 1, 3'd6, 4'b0010, 0, 1, 0);
        add(0, 1, 3'd7, 4'b0001, 1, 0, 0);
        add(0, 1, 3'd2, 4'b0001, 0, 1, 0);
        add(0, 1, 3'd3, 4'b0001, 1, 0, 0);
        add(0, 1, 3'd3, 4'b1001, 1, 0, 0);
        add(0, 1, 3'd3, 4'b1001, 1, 0, 0);
        add(0, 1, 3'd3, 4'b1001, 1, 0, 1);
        // Even up-by-two with the 6->0 wrap.
        add(1, 0, 3'd0, 4'b0000, 0, 0, 0);
        add(0, 1, 3'd0, 4'b0000, 0, 0, 0);
        add(0, 1, 3'd2, 4'b0011, 1, 0, 0);
        add(0, 1, 3'd4, 4'b0011, 1, 0, 0);
        add(0, 1, 3'd6, 4'b0011, 1, 0, 0);
        add(0, 1, 3'd0, 4'b0011, 1, 0, 1);
        // Odd down-by-two, a delta-5 jump, then 0->7 and the 7->0 wrap.
        add(1, 0, 3'd0, 4'b0000, 0, 0, 0);
        add(0, 1, 3'd1, 4'b0000, 0, 0, 0);
        add(0, 1, 3'd7, 4'b0100, 1, 0, 0);
        add(0, 1, 3'd5, 4'b0100, 1, 0, 0);
        add(0, 1, 3'd3, 4'b0100, 1, 0, 0);
        add(0, 1, 3'd0, 4'b0100, 0, 1, 0);
        add(0, 1, 3'd7, 4'b0100, 1, 0, 0);
        add(0, 1, 3'd0, 4'b0001, 1, 0, 0);
        add(0, 1, 3'd1, 4'b0001, 1, 0, 0);
        add(0, 1, 3'd2, 4'b0001, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset mid-stream with cnt_vld held high.
        @(negedge clk);
        cnt_vld = 1'b1;
        cnt_in  = 3'd3;
        reset   = 1'b1;
        #1;
        check("async_rst_x_out",   32'(x_out),   32'd0);
        check("async_rst_x_vld",   32'(x_vld),   32'd0);
        check("async_rst_locked",  32'(locked),  32'd0);
        check("async_rst_illegal", 32'(illegal), 32'd0);
        check("async_rst_err_cnt", 32'(err_cnt), 32'd0);

        // First sample after release is never judged; the next one is.
        v.rst = 0; v.vld = 1; v.cnt = 3'd5; v.x = 4'b0000; v.xv = 0; v.il = 0; v.lk = 0;
        exp_err = '0;
        apply(v);
        v.cnt = 3'd6; v.x = 4'b0001; v.xv = 1;
        apply(v);
        v.vld = 0; v.cnt = 3'd2; v.xv = 0;
        apply(v);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
